mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_BITS, default 16, number of implemented word-address bits in the attached ram (2^ADDR_BITS words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch request; if_addr held stable until if_ready.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_ready  output  1  combinational accept strobe for the fetch port.
REQ-007 if_valid  output  1  one-cycle pulse, if_data/if_err valid.
REQ-008 if_data  output  32  fetched instruction word.
REQ-009 if_err  output  1  qualifies if_valid: address out of range.
REQ-010 ls_req  input  1  load/store request; ls_we/ls_addr/ls_wdata held stable until ls_ready.
REQ-011 ls_we  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  32  load/store word address.
REQ-013 ls_wdata  input  32  store data.
REQ-014 ls_ready  output  1  combinational accept strobe for the load/store port.
REQ-015 ls_valid  output  1  one-cycle pulse: load data valid or store acknowledged.
REQ-016 ls_rdata  output  32  load data (0 for stores and errors).
REQ-017 ls_err  output  1  qualifies ls_valid: address out of range.
REQ-018 mem_addr, mem_din  output  32 each  registered ram address/write data.
REQ-019 mem_rw  output  2  registered ram op: 00 fetch, 01 read, 10 write; 11 never driven.
REQ-020 mem_enable  output  1  registered ram enable.
REQ-021 mem_dout, mem_fetch  input  32 each  ram read-data and fetch-data returns (registered in the ram, 1-edge latency).

Function
REQ-022 States: IDLE, ISSUE, CAPTURE; accept only in IDLE, at most one port per cycle.
REQ-023 Arbitration in IDLE: single requester wins; both pending -> grant port opposite to last_grant; last_grant updates on every accept.
REQ-024 Accept edge E0 (req && ready): mem_addr<=addr, mem_rw<=op code, mem_din<=ls_wdata (stores only, else unchanged), mem_enable<=1, state->ISSUE.
REQ-025 ISSUE edge E1: mem_enable<=0; store -> IDLE with ls_valid=1, ls_rdata=0; fetch/load -> CAPTURE.
REQ-026 CAPTURE edge E2: if_data<=mem_fetch (fetch) or ls_rdata<=mem_dout (load), sampled pre-edge; state->IDLE with corresponding valid=1.
REQ-027 Latency from accept edge to valid cycle: store 1 edge, fetch/load 2 edges; valid asserted in the IDLE cycle, a new accept allowed in that same cycle.
REQ-028 Out of range (any addr bit >= ADDR_BITS set): accepted, mem_enable stays 0, next edge -> IDLE with valid=1, err=1, data=0; last_grant still updates.
REQ-029 valid, err, ready low in all other cycles; if_data/ls_rdata hold their last value between pulses except as set by REQ-025/028.
REQ-030 Requests deasserted before ready are dropped silently; no internal request queueing.

Reset
REQ-031 rst at an edge overrides all transitions: state=IDLE, mem_enable=0, mem_rw=00, mem_addr=0, mem_din=0, all valid/err=0, if_data=ls_rdata=0, last_grant=fetch (first tie goes to load/store).
REQ-032 Reset mid-operation aborts without a valid pulse; a store already presented with mem_enable=1 at the reset edge completes in the ram (ram has no reset).
REQ-033 ready outputs are 0 during any cycle with rst high.

Verification
REQ-034 Store then load: ls store addr 0x10 data 0xDEADBEEF -> mem_rw=10 one cycle, ls_valid 1 edge after accept; load 0x10 -> ls_rdata=0xDEADBEEF, ls_valid 2 edges after accept.
REQ-035 Fetch: preload word 0x20=0x12345678, if_req addr 0x20 -> mem_rw=00, if_data=0x12345678, if_valid 2 edges after accept, if_err=0.
REQ-036 Tie arbitration after reset: if_req and ls_req held high continuously -> grant order ls, if, ls, if; each port gets a valid per grant.
REQ-037 Out of range: ls load addr 0x0001_0000 (ADDR_BITS=16) -> mem_enable never 1, ls_valid=1, ls_err=1, ls_rdata=0 one edge after accept.
REQ-038 Reset mid-load: rst high during CAPTURE -> no ls_valid, state IDLE, all outputs at REQ-031 values next cycle.
REQ-039 Back-to-back: load accepted in the same cycle as previous ls_valid -> second data returned 3 cycles after first.

Source files
------------

// File: rtl/mem_ctrl.sv
// Two-port (fetch / load-store) arbiter and sequencer for a single-ported synchronous ram.
// One access in flight at a time; the ram returns data one edge after the enable edge.
module mem_ctrl #(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic        if_valid_o,
    output logic [31:0] if_data_o,
    output logic        if_err_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_ready_o,
    output logic        ls_valid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    output logic [1:0]  mem_rw_o,
    output logic        mem_enable_o,
    input  logic [31:0] mem_dout_i,
    input  logic [31:0] mem_fetch_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    localparam logic [1:0] RwFetch = 2'b00;
    localparam logic [1:0] RwRead  = 2'b01;
    localparam logic [1:0] RwWrite = 2'b10;

    localparam logic GrantIf = 1'b0;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic [1:0]  mem_rw_q, mem_rw_d;
    logic        mem_en_q, mem_en_d;
    logic        if_valid_q, if_valid_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_valid_q, ls_valid_d;
    logic        ls_err_q, ls_err_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic grant_if, grant_ls;
    logic if_in_range, ls_in_range;

    // On a tie the port opposite to the previous winner is granted.
    assign grant_ls = ls_req_i && (!if_req_i || (last_grant_q == GrantIf));
    assign grant_if = if_req_i && !grant_ls;

    assign if_in_range = (if_addr_i >> ADDR_BITS) == 32'd0;
    assign ls_in_range = (ls_addr_i >> ADDR_BITS) == 32'd0;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (if_ready_o || ls_ready_o) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (err_q || (mem_rw_q == RwWrite)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        if_ready_o   = 1'b0;
        ls_ready_o   = 1'b0;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_rw_d     = mem_rw_q;
        mem_en_d     = 1'b0;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        if_data_d    = if_data_q;
        ls_valid_d   = 1'b0;
        ls_err_d     = 1'b0;
        ls_rdata_d   = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                if_ready_o = !rst_i && grant_if;
                ls_ready_o = !rst_i && grant_ls;
                if (if_ready_o) begin
                    last_grant_d = 1'b0;
                    mem_addr_d   = if_addr_i;
                    mem_rw_d     = RwFetch;
                    mem_en_d     = if_in_range;
                    err_d        = !if_in_range;
                end else if (ls_ready_o) begin
                    last_grant_d = 1'b1;
                    mem_addr_d   = ls_addr_i;
                    mem_rw_d     = ls_we_i ? RwWrite : RwRead;
                    mem_en_d     = ls_in_range;
                    err_d        = !ls_in_range;
                    if (ls_we_i) begin
                        mem_din_d = ls_wdata_i;
                    end
                end
            end
            StIssue: begin
                if (err_q) begin
                    if (mem_rw_q == RwFetch) begin
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                        if_data_d  = 32'd0;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = 32'd0;
                    end
                end else if (mem_rw_q == RwWrite) begin
                    ls_valid_d = 1'b1;
                    ls_rdata_d = 32'd0;
                end
            end
            StCapture: begin
                if (mem_rw_q == RwFetch) begin
                    if_valid_d = 1'b1;
                    if_data_d  = mem_fetch_i;
                end else begin
                    ls_valid_d = 1'b1;
                    ls_rdata_d = mem_dout_i;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GrantIf;
            err_q        <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            mem_rw_q     <= RwFetch;
            mem_en_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            if_data_q    <= 32'd0;
            ls_valid_q   <= 1'b0;
            ls_err_q     <= 1'b0;
            ls_rdata_q   <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_rw_q     <= mem_rw_d;
            mem_en_q     <= mem_en_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
            if_data_q    <= if_data_d;
            ls_valid_q   <= ls_valid_d;
            ls_err_q     <= ls_err_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_din_o    = mem_din_q;
    assign mem_rw_o     = mem_rw_q;
    assign mem_enable_o = mem_en_q;
    assign if_valid_o   = if_valid_q;
    assign if_err_o     = if_err_q;
    assign if_data_o    = if_data_q;
    assign ls_valid_o   = ls_valid_q;
    assign ls_err_o     = ls_err_q;
    assign ls_rdata_o   = ls_rdata_q;

    a_rw_legal: assert property (@(posedge clk_i) disable iff (rst_i) mem_rw_q != 2'b11);
    a_one_ready: assert property (@(posedge clk_i) !(if_ready_o && ls_ready_o));

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural one-edge-latency ram attached.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready, if_valid, if_err;
    logic [31:0] if_data;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_valid, ls_err;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout, mem_fetch;
    logic [1:0]  mem_rw;
    logic        mem_enable;

    logic [31:0] ram [0:255];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_BITS(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_ready_o   (if_ready),
        .if_valid_o   (if_valid),
        .if_data_o    (if_data),
        .if_err_o     (if_err),
        .ls_req_i     (ls_req),
        .ls_we_i      (ls_we),
        .ls_addr_i    (ls_addr),
        .ls_wdata_i   (ls_wdata),
        .ls_ready_o   (ls_ready),
        .ls_valid_o   (ls_valid),
        .ls_rdata_o   (ls_rdata),
        .ls_err_o     (ls_err),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_rw_o     (mem_rw),
        .mem_enable_o (mem_enable),
        .mem_dout_i   (mem_dout),
        .mem_fetch_i  (mem_fetch)
    );

    always @(posedge clk) begin
        if (mem_enable) begin
            case (mem_rw)
                2'b10:   ram[mem_addr[7:0]] <= mem_din;
                2'b01:   mem_dout <= ram[mem_addr[7:0]];
                2'b00:   mem_fetch <= ram[mem_addr[7:0]];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int grants [4];
    int ng, ifv, lsv, t1, t2;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[8'h20] = 32'h1234_5678;
        ram[8'h14] = 32'hCAFE_F00D;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
        tick(); tick();

        // Reset state; ready held low while rst is high
        chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_enable}, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_valids", {28'd0, if_valid, if_err, ls_valid, ls_err}, 32'd0);
        chk("rst_data", if_data | ls_rdata, 32'd0);
        ls_req = 1'b0;
        rst = 1'b0;
        tick();

        // Store 0x10 <- DEADBEEF
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_ready", {31'd0, ls_ready}, 32'd1);
        tick();
        ls_req = 1'b0;
        chk("st_mem_rw", {30'd0, mem_rw}, 32'd2);
        chk("st_mem_en", {31'd0, mem_enable}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h10);
        chk("st_mem_din", mem_din, 32'hDEAD_BEEF);
        chk("st_valid_early", {31'd0, ls_valid}, 32'd0);
        tick();
        chk("st_valid", {30'd0, ls_valid, ls_err}, 32'd2);
        chk("st_rdata", ls_rdata, 32'd0);
        chk("st_mem_en_off", {31'd0, mem_enable}, 32'd0);
        tick();
        chk("st_valid_pulse", {31'd0, ls_valid}, 32'd0);

        // Load 0x10
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        tick();
        ls_req = 1'b0;
        chk("ld_mem_rw", {30'd0, mem_rw}, 32'd1);
        chk("ld_mem_en", {31'd0, mem_enable}, 32'd1);
        tick();
        chk("ld_valid_early", {31'd0, ls_valid}, 32'd0);
        tick();
        chk("ld_valid", {30'd0, ls_valid, ls_err}, 32'd2);
        chk("ld_rdata", ls_rdata, 32'hDEAD_BEEF);

        // Fetch 0x20
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        if_req = 1'b0;
        chk("if_mem_rw", {30'd0, mem_rw}, 32'd0);
        chk("if_mem_en", {31'd0, mem_enable}, 32'd1);
        tick();
        chk("if_valid_early", {31'd0, if_valid}, 32'd0);
        tick();
        chk("if_valid", {30'd0, if_valid, if_err}, 32'd2);
        chk("if_data", if_data, 32'h1234_5678);

        // Tie arbitration after reset: expect ls, if, ls, if
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        ng = 0; ifv = 0; lsv = 0;
        for (int c = 0; c < 20; c++) begin
            if (ifv + lsv == 4) break;
            #1;
            if (ng < 4 && ls_ready) begin grants[ng] = 1; ng++; end
            else if (ng < 4 && if_ready) begin grants[ng] = 0; ng++; end
            if (if_valid) ifv++;
            if (ls_valid) lsv++;
            tick();
            if (ng == 4) begin if_req = 1'b0; ls_req = 1'b0; end
        end
        chk("tie_ngrant", ng, 4);
        chk("tie_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 32'b1010);
        chk("tie_if_valids", ifv, 2);
        chk("tie_ls_valids", lsv, 2);
        chk("tie_data", {if_data[7:0], ls_rdata[7:0]}, 32'h78EF);

        // Out-of-range load
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0001_0000;
        tick();
        ls_req = 1'b0;
        chk("oor_mem_en", {31'd0, mem_enable}, 32'd0);
        chk("oor_valid_early", {31'd0, ls_valid}, 32'd0);
        tick();
        chk("oor_valid_err", {30'd0, ls_valid, ls_err}, 32'd3);
        chk("oor_rdata", ls_rdata, 32'd0);
        chk("oor_mem_en2", {31'd0, mem_enable}, 32'd0);

        // Out-of-range fetch
        if_req = 1'b1; if_addr = 32'hFFFF_FFFC;
        tick();
        if_req = 1'b0;
        chk("oor_if_mem_en", {31'd0, mem_enable}, 32'd0);
        tick();
        chk("oor_if_valid_err", {30'd0, if_valid, if_err}, 32'd3);
        chk("oor_if_data", if_data, 32'd0);

        // Refill ls_rdata, then reset during CAPTURE of a second load
        ls_req = 1'b1; ls_addr = 32'h10;
        tick(); ls_req = 1'b0; tick(); tick();
        chk("pre_rst_rdata", ls_rdata, 32'hDEAD_BEEF);
        ls_req = 1'b1;
        tick(); ls_req = 1'b0; tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", {31'd0, ls_valid}, 32'd0);
        chk("midrst_rdata", ls_rdata, 32'd0);
        chk("midrst_mem", {mem_addr[29:0], mem_rw}, 32'd0);
        chk("midrst_mem_en", {31'd0, mem_enable}, 32'd0);
        tick();
        chk("midrst_no_valid", {31'd0, ls_valid}, 32'd0);

        // Back-to-back loads: second accepted in the first valid cycle
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        tick();
        ls_addr = 32'h14;
        t1 = -1; t2 = -1;
        for (int c = 0; c < 12; c++) begin
            if (ls_valid && t1 < 0) begin
                t1 = cyc;
                chk("b2b_first", ls_rdata, 32'hDEAD_BEEF);
                chk("b2b_same_cycle_ready", {31'd0, ls_ready}, 32'd1);
                tick();
                ls_req = 1'b0;
            end else if (ls_valid && t2 < 0) begin
                t2 = cyc;
                chk("b2b_second", ls_rdata, 32'hCAFE_F00D);
                break;
            end else begin
                tick();
            end
        end
        chk("b2b_spacing", t2 - t1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
